// File: rtl/id_seq_checker.sv
// Tracks the 9-digit ID stream (8,1,0,4,4,0,0,2,3), registered outputs one cycle after each sampled digit; no backpressure.
// Optional error counter port oErrCnt when CHK_ERRCNT_EN is defined.
module id_seq_checker #(
  parameter int CNT_W = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  input  logic [3:0]       iNum,
  output logic             oMatch,
  output logic             oLock,
  output logic             oErr,
  output logic [CNT_W-1:0] oMatchCnt,
`ifdef CHK_ERRCNT_EN
  output logic [CNT_W-1:0] oErrCnt,
`endif
  output logic [3:0]       oIdx
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             match_q, match_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;

  function automatic logic [3:0] exp_digit(input logic [3:0] idx);
    case (idx)
      4'd0:    exp_digit = 4'd8;
      4'd1:    exp_digit = 4'd1;
      4'd2:    exp_digit = 4'd0;
      4'd3:    exp_digit = 4'd4;
      4'd4:    exp_digit = 4'd4;
      4'd5:    exp_digit = 4'd0;
      4'd6:    exp_digit = 4'd0;
      4'd7:    exp_digit = 4'd2;
      4'd8:    exp_digit = 4'd3;
      default: exp_digit = 4'd0;
    endcase
  endfunction

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= SEARCH;
      idx_q   <= 4'd0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      err_q   <= err_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    match_d = 1'b0;
    err_d   = 1'b0;
    mcnt_d  = mcnt_q;
    if (iValid) begin
      if (iNum == exp_digit(idx_q)) begin
        if (idx_q == 4'd8) begin
          match_d = 1'b1;
          idx_d   = 4'd0;
          state_d = LOCKED;
          if (mcnt_q != '1) mcnt_d = mcnt_q + CNT_W'(1);
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end else begin
        // 8 appears only at position 0, so it is the only useful overlap restart
        idx_d = (iNum == 4'd8) ? 4'd1 : 4'd0;
        if (state_q == LOCKED) begin
          err_d   = 1'b1;
          state_d = SEARCH;
        end
      end
    end
  end

  assign oMatch    = match_q;
  assign oErr      = err_q;
  assign oLock     = (state_q == LOCKED);
  assign oMatchCnt = mcnt_q;
  assign oIdx      = idx_q;

`ifdef CHK_ERRCNT_EN
  logic [CNT_W-1:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    if (err_d && (ecnt_q != '1)) ecnt_d = ecnt_q + CNT_W'(1);
  end

  always_ff @(posedge iClk) begin
    if (iRst) ecnt_q <= '0;
    else      ecnt_q <= ecnt_d;
  end

  assign oErrCnt = ecnt_q;
`endif

endmodule

// File: tb/tb_id_seq_checker.sv
// Directed bench for id_seq_checker: a default-width instance plus a CNT_W=2 instance for saturation.
module tb_id_seq_checker;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       iValid = 1'b0;
  logic [3:0] iNum = 4'd0;

  logic       m_a, l_a, e_a, m_b, l_b, e_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [3:0] idx_a, idx_b;
`ifdef CHK_ERRCNT_EN
  logic [7:0] ecnt_a;
  logic [1:0] ecnt_b;
`endif

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] id_tab [9] = '{4'd8, 4'd1, 4'd0, 4'd4, 4'd4, 4'd0, 4'd0, 4'd2, 4'd3};

  always #5 iClk = ~iClk;

  id_seq_checker #(.CNT_W(8)) u_dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iNum(iNum),
    .oMatch(m_a), .oLock(l_a), .oErr(e_a), .oMatchCnt(cnt_a),
`ifdef CHK_ERRCNT_EN
    .oErrCnt(ecnt_a),
`endif
    .oIdx(idx_a)
  );

  id_seq_checker #(.CNT_W(2)) u_dut2 (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iNum(iNum),
    .oMatch(m_b), .oLock(l_b), .oErr(e_b), .oMatchCnt(cnt_b),
`ifdef CHK_ERRCNT_EN
    .oErrCnt(ecnt_b),
`endif
    .oIdx(idx_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of input, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [3:0] d);
    iValid = v;
    iNum   = d;
    @(posedge iClk);
    #1;
  endtask

  task automatic digit(input logic [3:0] d, input logic exp_match, input logic exp_err);
    step(1'b1, d);
    chk("match", {31'd0, m_a}, {31'd0, exp_match});
    chk("err",   {31'd0, e_a}, {31'd0, exp_err});
  endtask

  task automatic send_id(input int exp_cnt);
    for (int i = 0; i < 9; i++) digit(id_tab[i], (i == 8), 1'b0);
    chk("lock_after_id", {31'd0, l_a}, 32'd1);
    chk("idx_after_id",  {28'd0, idx_a}, 32'd0);
    chk("cnt_after_id",  {24'd0, cnt_a}, exp_cnt);
  endtask

  initial begin
    // Reset asserted with a valid digit present: reset must win.
    iRst = 1'b1;
    step(1'b1, 4'd8);
    chk("rst_match", {31'd0, m_a}, 32'd0);
    chk("rst_lock",  {31'd0, l_a}, 32'd0);
    chk("rst_err",   {31'd0, e_a}, 32'd0);
    chk("rst_cnt",   {24'd0, cnt_a}, 32'd0);
    chk("rst_idx",   {28'd0, idx_a}, 32'd0);
    iRst = 1'b0;

    // Leading 0 from the generator is a harmless SEARCH mismatch.
    digit(4'd0, 1'b0, 1'b0);
    chk("lead0_idx", {28'd0, idx_a}, 32'd0);

    // First ID, then two more back-to-back.
    send_id(1);
    send_id(2);
    send_id(3);

    // Locked: 5 replaces the 4 at idx 3.
    digit(4'd8, 1'b0, 1'b0);
    digit(4'd1, 1'b0, 1'b0);
    digit(4'd0, 1'b0, 1'b0);
    chk("pre_err_idx", {28'd0, idx_a}, 32'd3);
    digit(4'd5, 1'b0, 1'b1);
    chk("err_lock", {31'd0, l_a}, 32'd0);
    chk("err_idx",  {28'd0, idx_a}, 32'd0);
    send_id(4);
`ifdef CHK_ERRCNT_EN
    chk("errcnt1", {24'd0, ecnt_a}, 32'd1);
`endif

    // Drop to SEARCH, then overlapping 8,1,8,1,...
    digit(4'd7, 1'b0, 1'b1);
    chk("drop_lock", {31'd0, l_a}, 32'd0);
    digit(4'd8, 1'b0, 1'b0);
    digit(4'd1, 1'b0, 1'b0);
    chk("ovl_idx2", {28'd0, idx_a}, 32'd2);
    digit(4'd8, 1'b0, 1'b0);
    chk("ovl_idx1", {28'd0, idx_a}, 32'd1);
    for (int i = 1; i < 9; i++) digit(id_tab[i], (i == 8), 1'b0);
    chk("ovl_lock",  {31'd0, l_a}, 32'd1);
    chk("ovl_cnt",   {24'd0, cnt_a}, 32'd5);
    chk("sat_cnt",   {30'd0, cnt_b}, 32'd3);
    chk("sat_match", {31'd0, m_b}, 32'd1);
`ifdef CHK_ERRCNT_EN
    chk("errcnt2",   {24'd0, ecnt_a}, 32'd2);
    chk("errcnt2_b", {30'd0, ecnt_b}, 32'd2);
`endif

    // Valid gap mid-ID: idx holds, no pulses, garbage digit ignored.
    for (int i = 0; i < 4; i++) digit(id_tab[i], 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'd5);
      chk("gap_idx",   {28'd0, idx_a}, 32'd4);
      chk("gap_match", {31'd0, m_a}, 32'd0);
      chk("gap_err",   {31'd0, e_a}, 32'd0);
      chk("gap_lock",  {31'd0, l_a}, 32'd1);
    end
    for (int i = 4; i < 9; i++) digit(id_tab[i], (i == 8), 1'b0);
    chk("gap_cnt", {24'd0, cnt_a}, 32'd6);
    chk("gap_cnt_b", {30'd0, cnt_b}, 32'd3);

    // Reset after 5 digits of a new ID.
    for (int i = 0; i < 5; i++) digit(id_tab[i], 1'b0, 1'b0);
    chk("mid_idx", {28'd0, idx_a}, 32'd5);
    iRst = 1'b1;
    step(1'b1, 4'd0);
    iRst = 1'b0;
    chk("rst2_lock",  {31'd0, l_a}, 32'd0);
    chk("rst2_cnt",   {24'd0, cnt_a}, 32'd0);
    chk("rst2_cnt_b", {30'd0, cnt_b}, 32'd0);
    chk("rst2_idx",   {28'd0, idx_a}, 32'd0);
    chk("rst2_match", {31'd0, m_a}, 32'd0);
`ifdef CHK_ERRCNT_EN
    chk("rst2_errcnt", {24'd0, ecnt_a}, 32'd0);
`endif
    send_id(1);
    step(1'b0, 4'd0);
    chk("post_match_clear", {31'd0, m_a}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
